// File: rtl/fft_frame_sequencer.sv
// Frame-level controller for the FFT -> IFFT audio datapath.
// Sequence per frame: accept the frame, pulse the forward transform, wait for
// its done, pulse the inverse transform, wait for its done, then hand the frame
// to the output writer. Samples are counted against the file size latched at start.
module fft_frame_sequencer #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [CNT_W-1:0] load_size,
    input  logic             flag_clear,
    input  logic             frame_valid,
    output logic             frame_ready,
    output logic             fft_start,
    input  logic             fft_done,
    output logic             ifft_start,
    input  logic             ifft_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] sample_count,
    output logic             busy,
    output logic             wav_done,
    output logic             error
);

    localparam int               TMR_W   = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        FFT,
        IFFT,
        OUT,
        DONE,
        ERR
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   size_q, size_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               fft_start_q, fft_start_d;
    logic               ifft_start_q, ifft_start_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               wav_done_q, wav_done_d;
    logic               error_q, error_d;
    // One extra bit so the running total can be compared without wrapping.
    logic [CNT_W:0]     count_sum;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        size_d    = size_q;
        count_d   = count_q;
        count_sum = {1'b0, count_q} + (CNT_W+1)'(FRAME_LEN);

        if (flag_clear) begin
            // Abort/acknowledge beats every other event.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        size_d  = load_size;
                        count_d = '0;
                        state_d = (load_size == '0) ? DONE : WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (frame_valid) begin
                        state_d = FFT;
                        timer_d = '0;
                    end
                end
                FFT: begin
                    // Done is not trusted in the cycle the start pulse is out.
                    if (fft_done && !fft_start_q) begin
                        state_d = IFFT;
                        timer_d = '0;
                    end else if (timer_q == TMR_MAX) begin
                        state_d = ERR;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                IFFT: begin
                    if (ifft_done && !ifft_start_q) begin
                        state_d = OUT;
                        timer_d = '0;
                    end else if (timer_q == TMR_MAX) begin
                        state_d = ERR;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        // Saturate rather than wrap if the count ever tops out.
                        count_d = count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0];
                        state_d = (count_sum >= {1'b0, size_q}) ? DONE : WAIT_FRAME;
                    end
                end
                DONE:    state_d = DONE;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end

        // Registered outputs are decoded from the state being entered.
        fft_start_d  = (state_q == WAIT_FRAME) && (state_d == FFT);
        ifft_start_d = (state_q == FFT) && (state_d == IFFT);
        out_valid_d  = (state_d == OUT);
        wav_done_d   = (state_d == DONE);
        error_d      = (state_d == ERR);
        busy_d       = (state_d == WAIT_FRAME) || (state_d == FFT) ||
                       (state_d == IFFT) || (state_d == OUT);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            size_q       <= '0;
            count_q      <= '0;
            fft_start_q  <= 1'b0;
            ifft_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            wav_done_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            size_q       <= size_d;
            count_q      <= count_d;
            fft_start_q  <= fft_start_d;
            ifft_start_q <= ifft_start_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            wav_done_q   <= wav_done_d;
            error_q      <= error_d;
        end
    end

    assign frame_ready  = (state_q == WAIT_FRAME);
    assign fft_start    = fft_start_q;
    assign ifft_start   = ifft_start_q;
    assign out_valid    = out_valid_q;
    assign sample_count = count_q;
    assign busy         = busy_q;
    assign wav_done     = wav_done_q;
    assign error        = error_q;

endmodule
